simd_alu_pipe: RTL and testbench
================================

Name: simd_alu_pipe

Overview:
- Clocked, parametrised successor to the combinational 64-bit vector ALU.
- Operand width is generalised to DATA_W, a multiple of 64. Each 64-bit slice is split into lanes of 8, 16, 32 or 64 bits, selected by ww.
- Inputs and outputs use valid/ready handshakes. Simple ops complete in one cycle; VDIV/VMOD run on a lane-parallel iterative divider.
- Sits between register-file read and writeback in the vector datapath.

Parameters:
- DATA_W, 64: operand/result width. Must be a multiple of 64. Bit 0 is the MSB; lane 0 occupies the most significant bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready at the clk edge
- ra  in  [0:DATA_W-1]  operand A
- rb  in  [0:DATA_W-1]  operand B (divisor, or shift amount)
- r_ins  in  6  function code
- ww  in  2  lane width: 00=8, 01=16, 10=32, 11=64
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- alu_out  out  [0:DATA_W-1]  result
- div_zero  out  1  at least one lane of a VDIV/VMOD result had a zero divisor
- op_err  out  1  result came from an illegal r_ins

Behaviour:
- Reset: all outputs are 0, state is IDLE, and any in-flight division is discarded. Reset is asynchronous and may arrive mid-operation.
- Function codes:
  - 000001 VAND, 000010 VOR, 000011 VXOR, 000100 VNOT (of ra), 000101 VMOV (of ra).
  - 000110 VADD, 000111 VSUB: per lane, modulo 2^W; carries never cross lanes.
  - 001010 VSLL, 001011 VSRL, 001100 VSRA: shift amount is the low log2(W) bits of the same lane of rb.
  - 001110 VDIV, 001111 VMOD: unsigned per lane.
- Illegal code: alu_out=0 and op_err=1, with single-cycle latency.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new result may load in the same cycle the old one drains.
- Simple ops: result is registered on the accept edge, so out_valid rises one cycle after acceptance.
- Output hold: alu_out, div_zero and op_err stay stable while out_valid && !out_ready.
- FSM IDLE:
  - Accepting VDIV/VMOD latches operands, r_ins and ww, clears the counter, and moves to DIV.
  - Accepting any other code stays in IDLE.
- FSM DIV:
  - Restoring division, one quotient bit per lane per cycle, for W cycles.
  - On the final iteration edge, loads the quotient (VDIV) or remainder (VMOD) into alu_out, sets out_valid, and returns to IDLE.
  - Total latency from the accept edge to out_valid is W+1 cycles: 9, 17, 33 or 65.
  - in_ready=0 throughout DIV. The output register is empty on completion by construction, so no stall state is needed.
- Zero divisor in a lane: quotient lane = all ones, remainder lane = dividend, div_zero=1. Other lanes are unaffected.
- div_zero is cleared on any load of a non-division result.

Optional Feature:
- SIMD_ALU_SAT_EN defined: adds 010011 VADDS and 010100 VSUBS. These are unsigned saturating per lane (clamp to 2^W-1 and to 0 respectively) with single-cycle latency.
- SIMD_ALU_SAT_EN undefined: those codes are illegal (alu_out=0, op_err=1).

Decomposition:
- Package simd_alu_pkg holds:
  - localparams for every r_ins code and each ww encoding;
  - a function returning lane width from ww;
  - FSM state encoding.
- Sub-module simd_lane_divider holds the iterative restoring divider across DATA_W with a lane-boundary mask per ww. It handles start/done, the counter and zero-divisor detect.

Test Plan:
- VADD ww=00, ra=FFFFFFFF_FFFFFFFF, rb=1234FFFF_1111FEC1 -> alu_out=1133FEFE_1010FDC0, one cycle after accept, op_err=0.
- VSUB ww=10, ra=FFFFFFFF_FFFFFFFF, rb=0F0F0F0F_11111111 -> F0F0F0F0_EEEEEEEE. VSLL ww=00, ra=F0E1F2A2_01010101, rb=00030001_020FF00A -> F008F244_04800104.
- VDIV ww=00, ra=FF123456_78786345, rb=FFFF3401_FFDE3211 -> 01000156_00000104 after 9 cycles, in_ready=0 during DIV. A second VDIV with rb=FF00FF00_FF00FF00 -> lanes 1,3,5,7 = FF, div_zero=1.
- VMOD ww=11, ra=102, rb=10 -> 00000000_00000002 after 65 cycles. Assert rst_n low at iteration 30 of a repeat: out_valid=0 immediately, in_ready=1 after release.
- Backpressure: out_ready=0 for 5 cycles after a VAND result -> alu_out stable, in_ready=0. Release out_ready alongside a queued VOR -> back-to-back results with no bubble.
- Illegal r_ins=111111 -> alu_out=0, op_err=1. With SIMD_ALU_SAT_EN, VADDS ww=00 with ra lane F0, rb lane 20 -> FF. Without the macro, the same stimulus -> op_err=1.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// simd_alu_pkg: shared codes, lane encodings and FSM states for simd_alu_pipe.
// Saturating ops exist only when SIMD_ALU_SAT_EN is defined.
package simd_alu_pkg;

  localparam logic [5:0] OP_VAND  = 6'b000001;
  localparam logic [5:0] OP_VOR   = 6'b000010;
  localparam logic [5:0] OP_VXOR  = 6'b000011;
  localparam logic [5:0] OP_VNOT  = 6'b000100;
  localparam logic [5:0] OP_VMOV  = 6'b000101;
  localparam logic [5:0] OP_VADD  = 6'b000110;
  localparam logic [5:0] OP_VSUB  = 6'b000111;
  localparam logic [5:0] OP_VSLL  = 6'b001010;
  localparam logic [5:0] OP_VSRL  = 6'b001011;
  localparam logic [5:0] OP_VSRA  = 6'b001100;
  localparam logic [5:0] OP_VDIV  = 6'b001110;
  localparam logic [5:0] OP_VMOD  = 6'b001111;
  localparam logic [5:0] OP_VADDS = 6'b010011;
  localparam logic [5:0] OP_VSUBS = 6'b010100;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  function automatic int unsigned lane_w(input logic [1:0] ww);
    return 32'd8 << ww;
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return (op == OP_VDIV) || (op == OP_VMOD);
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OP_VAND), (op == OP_VOR),
      (op == OP_VXOR), (op == OP_VNOT),
      (op == OP_VMOV), (op == OP_VADD),
      (op == OP_VSUB), (op == OP_VSLL),
      (op == OP_VSRL), (op == OP_VSRA),
      (op == OP_VDIV), (op == OP_VMOD):
        ok = 1'b1;
`ifdef SIMD_ALU_SAT_EN
      (op == OP_VADDS), (op == OP_VSUBS):
        ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/simd_lane_divider.sv
// simd_lane_divider: lane-parallel restoring divider, one quotient
// bit per lane per cycle; lane boundaries follow the latched ww.
module simd_lane_divider
  import simd_alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [1:0]        ww,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              div_zero
);

  logic              busy;
  logic [6:0]        cnt;
  logic [1:0]        wsel;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q_step;
  logic [DATA_W-1:0] r_step;

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int W = 8 << g;
    localparam int N = DATA_W / W;
    logic [DATA_W-1:0] qn;
    logic [DATA_W-1:0] rn;
    logic [N-1:0]      zl;
    for (genvar l = 0; l < N; l++) begin : g_l
      logic [W:0]   rs;
      logic [W-1:0] rd;
      logic [W-1:0] dl;
      logic         ge;
      assign dl = d[l*W +: W];
      assign rs = {r[l*W +: W], q[l*W+W-1]};
      assign ge = rs >= {1'b0, dl};
      assign rd = rs[W-1:0] - dl;
      assign rn[l*W +: W] = ge ? rd : rs[W-1:0];
      assign qn[l*W +: W] = {q[l*W +: W-1], ge};
      assign zl[l] = (dl == '0);
    end
  end

  // pick the step result for the lane width of this division
  always_comb begin
    q_step   = g_w[0].qn;
    r_step   = g_w[0].rn;
    div_zero = |g_w[0].zl;
    case (wsel)
      WW_16: begin
        q_step   = g_w[1].qn;
        r_step   = g_w[1].rn;
        div_zero = |g_w[1].zl;
      end
      WW_32: begin
        q_step   = g_w[2].qn;
        r_step   = g_w[2].rn;
        div_zero = |g_w[2].zl;
      end
      WW_64: begin
        q_step   = g_w[3].qn;
        r_step   = g_w[3].rn;
        div_zero = |g_w[3].zl;
      end
      default: ;
    endcase
  end

  assign done = busy && (cnt == 7'(lane_w(wsel) - 1));
  assign quot = q_step;
  assign rem  = r_step;

  // operand latch on start, then W iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      wsel <= WW_8;
      q    <= '0;
      r    <= '0;
      d    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      wsel <= ww;
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
    end else if (busy) begin
      q   <= q_step;
      r   <= r_step;
      cnt <= cnt + 7'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: clocked SIMD ALU with valid/ready ports and an
// iterative divider. Define SIMD_ALU_SAT_EN for VADDS/VSUBS.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] ra,
  input  logic [0:DATA_W-1] rb,
  input  logic [5:0]        r_ins,
  input  logic [1:0]        ww,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] alu_out,
  output logic              div_zero,
  output logic              op_err
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res_simple;
  logic              accept;
  logic              is_div;
  logic              legal;
  logic              mod_q;
  logic              div_done;
  logic              div_dz;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  assign a        = ra;
  assign b        = rb;
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_div   = op_is_div(r_ins);
  assign legal    = op_legal(r_ins);

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int W  = 8 << g;
    localparam int SH = 3 + g;
    localparam int N  = DATA_W / W;
    logic [DATA_W-1:0] res;
    for (genvar l = 0; l < N; l++) begin : g_l
      logic [W-1:0]  x;
      logic [W-1:0]  y;
      logic [W-1:0]  r;
      logic [SH-1:0] amt;
      assign x   = a[l*W +: W];
      assign y   = b[l*W +: W];
      assign amt = y[SH-1:0];
`ifdef SIMD_ALU_SAT_EN
      logic [W:0] sum;
      logic [W:0] dif;
      assign sum = {1'b0, x} + {1'b0, y};
      assign dif = {1'b0, x} - {1'b0, y};
`endif
      // single-cycle lane function
      always_comb begin
        r = '0;
        case (r_ins)
          OP_VAND:  r = x & y;
          OP_VOR:   r = x | y;
          OP_VXOR:  r = x ^ y;
          OP_VNOT:  r = ~x;
          OP_VMOV:  r = x;
          OP_VADD:  r = x + y;
          OP_VSUB:  r = x - y;
          OP_VSLL:  r = x << amt;
          OP_VSRL:  r = x >> amt;
          OP_VSRA:  r = $signed(x) >>> amt;
`ifdef SIMD_ALU_SAT_EN
          OP_VADDS: r = sum[W] ? '1 : sum[W-1:0];
          OP_VSUBS: r = dif[W] ? '0 : dif[W-1:0];
`endif
          default:  r = '0;
        endcase
      end
      assign res[l*W +: W] = r;
    end
  end

  // lane-width select of the simple result
  always_comb begin
    res_simple = g_w[0].res;
    case (ww)
      WW_16:   res_simple = g_w[1].res;
      WW_32:   res_simple = g_w[2].res;
      WW_64:   res_simple = g_w[3].res;
      default: ;
    endcase
  end

  simd_lane_divider #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_div),
    .dividend(a),
    .divisor (b),
    .ww      (ww),
    .done    (div_done),
    .quot    (div_q),
    .rem     (div_r),
    .div_zero(div_dz)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_div) state_nxt = ST_DIV;
      ST_DIV:  if (div_done)         state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // remember whether the running division wants the remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mod_q <= 1'b0;
    else if (accept && is_div) mod_q <= (r_ins == OP_VMOD);
  end

  // output register: load, hold under backpressure, or drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      div_zero  <= 1'b0;
      op_err    <= 1'b0;
    end else if (div_done) begin
      out_valid <= 1'b1;
      alu_out   <= mod_q ? div_r : div_q;
      div_zero  <= div_dz;
      op_err    <= 1'b0;
    end else if (accept && !is_div) begin
      out_valid <= 1'b1;
      alu_out   <= legal ? res_simple : '0;
      div_zero  <= 1'b0;
      op_err    <= !legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: vector table, hand sequences and random ops
// against a lane-arithmetic reference model.
module tb_simd_alu_pipe;

  localparam logic [5:0] C_AND  = 6'b000001;
  localparam logic [5:0] C_OR   = 6'b000010;
  localparam logic [5:0] C_XOR  = 6'b000011;
  localparam logic [5:0] C_NOT  = 6'b000100;
  localparam logic [5:0] C_MOV  = 6'b000101;
  localparam logic [5:0] C_ADD  = 6'b000110;
  localparam logic [5:0] C_SUB  = 6'b000111;
  localparam logic [5:0] C_SLL  = 6'b001010;
  localparam logic [5:0] C_SRL  = 6'b001011;
  localparam logic [5:0] C_SRA  = 6'b001100;
  localparam logic [5:0] C_DIV  = 6'b001110;
  localparam logic [5:0] C_MOD  = 6'b001111;
  localparam logic [5:0] C_ADDS = 6'b010011;
  localparam logic [5:0] C_SUBS = 6'b010100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] ra = '0;
  logic [63:0] rb = '0;
  logic [5:0]  r_ins = '0;
  logic [1:0]  ww = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] alu_out;
  logic        div_zero;
  logic        op_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  simd_alu_pipe #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ra(ra), .rb(rb), .r_ins(r_ins), .ww(ww),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .div_zero(div_zero), .op_err(op_err)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [1:0]  ww;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        dz;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      C_AND, C_OR, C_XOR, C_NOT, C_MOV, C_ADD, C_SUB,
      C_SLL, C_SRL, C_SRA, C_DIV, C_MOD: return 1'b1;
`ifdef SIMD_ALU_SAT_EN
      C_ADDS, C_SUBS: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model(input logic [5:0] op, input logic [1:0] w_sel,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic dz,
                                output logic err);
    int w;
    int n;
    longint unsigned mask;
    res = '0;
    dz  = 1'b0;
    err = !is_legal(op);
    w = 8 << w_sel;
    n = 64 / w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    if (err) return;
    for (int l = 0; l < n; l++) begin
      int sh;
      int amt;
      longint unsigned x, y, r, s;
      sh = 64 - w * (l + 1);
      x = (a >> sh) & mask;
      y = (b >> sh) & mask;
      amt = int'(y % longint'(w));
      r = 0;
      case (op)
        C_AND: r = x & y;
        C_OR:  r = x | y;
        C_XOR: r = x ^ y;
        C_NOT: r = ~x & mask;
        C_MOV: r = x;
        C_ADD: r = (x + y) & mask;
        C_SUB: r = (x - y) & mask;
        C_SLL: r = (x << amt) & mask;
        C_SRL: r = x >> amt;
        C_SRA: begin
          r = x >> amt;
          if (((x >> (w - 1)) & 1) == 1) r = r | (mask & ~(mask >> amt));
        end
        C_DIV: if (y == 0) begin r = mask; dz = 1'b1; end else r = x / y;
        C_MOD: if (y == 0) begin r = x; dz = 1'b1; end else r = x % y;
        C_ADDS: begin
          s = (x + y) & mask;
          r = (s < x) ? mask : s;
        end
        C_SUBS: r = (x < y) ? 0 : x - y;
        default: r = 0;
      endcase
      res = res | (r << sh);
    end
  endfunction

  task automatic do_op(input logic [5:0] op, input logic [1:0] w,
                       input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] res, output logic dz,
                       output logic err, output int lat, output int rdy_hi);
    int n;
    @(negedge clk);
    r_ins = op; ww = w; ra = x; rb = y;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_hi = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hi++;
      @(negedge clk);
      lat++;
    end
    res = alu_out; dz = div_zero; err = op_err;
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic [1:0] w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] e, input logic dz, input logic err);
    vec_t v;
    v.name = nm; v.op = op; v.ww = w; v.a = a; v.b = b;
    v.exp = e; v.dz = dz; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] res, e1, e2, x, y, zm;
    logic dz, err, edz, eerr;
    logic [5:0] op;
    logic [1:0] w;
    int lat, rdy, elat, cnt;

    add("vadd8", C_ADD, 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h1234FFFF_1111FEC1,
        64'h1133FEFE_1010FDC0, 0, 0);
    add("vsub32", C_SUB, 2'b10, 64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_11111111,
        64'hF0F0F0F0_EEEEEEEE, 0, 0);
    add("vsll8", C_SLL, 2'b00, 64'hF0E1F2A2_01010101, 64'h00030001_020FF00A,
        64'hF008F244_04800104, 0, 0);
    add("vdiv8", C_DIV, 2'b00, 64'hFF123456_78786345, 64'hFFFF3401_FFDE3211,
        64'h01000156_00000104, 0, 0);
    add("vdiv8z", C_DIV, 2'b00, 64'hFF123456_78786345, 64'hFF00FF00_FF00FF00,
        64'h01FF00FF_00FF00FF, 1, 0);
    add("vmod64", C_MOD, 2'b11, 64'h102, 64'h10, 64'h2, 0, 0);
    add("vmod16z", C_MOD, 2'b01, 64'h1234_5678_9ABC_DEF0,
        64'h0000_0010_0000_0003, 64'h1234_0008_9ABC_0000, 1, 0);
    add("vdiv32", C_DIV, 2'b10, 64'hFFFFFFFF_00000064, 64'h00000010_00000007,
        64'h0FFFFFFF_0000000E, 0, 0);
    add("vsra16", C_SRA, 2'b01, 64'h8000_7FFF_F000_0F00,
        64'h0004_0004_000F_0001, 64'hF800_07FF_FFFF_0780, 0, 0);
    add("vsrl32", C_SRL, 2'b10, 64'h80000000_12345678, 64'h0000001F_00000004,
        64'h00000001_01234567, 0, 0);
    add("vnot", C_NOT, 2'b11, 64'h0123456789ABCDEF, 64'hFFFF,
        64'hFEDCBA9876543210, 0, 0);
    add("illegal", 6'b111111, 2'b00, 64'hFFFF, 64'h1, 64'h0, 0, 1);
`ifdef SIMD_ALU_SAT_EN
    add("vadds8", C_ADDS, 2'b00, 64'hF0F0F0F0_F0F0F0F0, 64'h20202020_20202020,
        64'hFFFFFFFF_FFFFFFFF, 0, 0);
`else
    add("vadds8", C_ADDS, 2'b00, 64'hF0F0F0F0_F0F0F0F0, 64'h20202020_20202020,
        64'h0, 0, 1);
`endif

    repeat (3) @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.alu_out", alu_out, 64'd0);
    chk("rst.div_zero", 64'(div_zero), 64'd0);
    chk("rst.op_err", 64'(op_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].ww, vecs[i].a, vecs[i].b, res, dz, err, lat, rdy);
      elat = (vecs[i].op == C_DIV || vecs[i].op == C_MOD) ? (8 << vecs[i].ww) + 1 : 1;
      chk({vecs[i].name, ".data"}, res, vecs[i].exp);
      chk({vecs[i].name, ".dz"}, 64'(dz), 64'(vecs[i].dz));
      chk({vecs[i].name, ".err"}, 64'(err), 64'(vecs[i].err));
      chk({vecs[i].name, ".lat"}, 64'(lat), 64'(elat));
      if (elat > 1) chk({vecs[i].name, ".busy_ready"}, 64'(rdy), 64'd0);
    end

    // backpressure, then queued op accepted as the old result drains
    @(negedge clk);
    out_ready = 1'b0;
    r_ins = C_AND; ww = 2'b00;
    ra = 64'hF0F0_1234_FFFF_0000; rb = 64'h3C3C_FF00_0F0F_FFFF;
    in_valid = 1'b1;
    model(C_AND, 2'b00, ra, rb, e1, edz, eerr);
    model(C_OR, 2'b01, 64'h1111_2222_3333_4444, 64'h8888_0000_0004_0003,
          e2, edz, eerr);
    @(posedge clk);
    @(negedge clk);
    r_ins = C_OR; ww = 2'b01;
    ra = 64'h1111_2222_3333_4444; rb = 64'h8888_0000_0004_0003;
    for (int k = 0; k < 5; k++) begin
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.hold", alu_out, e1);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.valid", 64'(out_valid), 64'd1);
    chk("b2b.data", alu_out, e2);
    @(negedge clk);
    chk("b2b.drain", 64'(out_valid), 64'd0);

    // reset in the middle of a long division
    @(negedge clk);
    r_ins = C_MOD; ww = 2'b11; ra = 64'h102; rb = 64'h10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", 64'(out_valid), 64'd0);
    chk("mid.rst_data", alu_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid.in_ready_rel", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("mid.no_stale", 64'(cnt), 64'd0);

    // random ops against the model
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 14))
        0: op = C_AND;  1: op = C_OR;   2: op = C_XOR;
        3: op = C_NOT;  4: op = C_MOV;  5: op = C_ADD;
        6: op = C_SUB;  7: op = C_SLL;  8: op = C_SRL;
        9: op = C_SRA;  10: op = C_DIV; 11: op = C_MOD;
        12: op = C_ADDS; 13: op = C_SUBS;
        default: op = 6'($urandom_range(0, 63));
      endcase
      w = 2'($urandom_range(0, 3));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ((op == C_DIV || op == C_MOD) && $urandom_range(0, 2) == 0) begin
        zm = '0;
        for (int k = 0; k < 8; k++)
          if ($urandom_range(0, 2) != 0) zm[k*8 +: 8] = 8'hFF;
        y = y & zm;
      end
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 40);
      model(op, w, x, y, e1, edz, eerr);
      elat = (op == C_DIV || op == C_MOD) ? (8 << w) + 1 : 1;
      do_op(op, w, x, y, res, dz, err, lat, rdy);
      chk($sformatf("rnd%0d.op%0h.w%0d.data", t, op, w), res, e1);
      chk($sformatf("rnd%0d.dz", t), 64'(dz), 64'(edz));
      chk($sformatf("rnd%0d.err", t), 64'(err), 64'(eerr));
      chk($sformatf("rnd%0d.lat", t), 64'(lat), 64'(elat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
